// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt pending/select stage and its bench model.
package irq_pkg;

    localparam int NSRC    = 32;
    localparam int CAUSE_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } irq_state_e;

    // Isolates the lowest set bit (two's complement trick); zero in, zero out.
    function automatic logic [NSRC-1:0] lowest_set(input logic [NSRC-1:0] x);
        return x & (-x);
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One-bit synchronizer with rise detection; emits a single-cycle pulse per rising edge.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // prev_q resets low, so a source already high at reset release counts as one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_pending_select.sv
// Interrupt pending stage: latches requests, masks with enable, grants the lowest
// enabled pending source as a registered one-hot vector held until acknowledged.
module irq_pending_select
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] irq_in,
    input  logic [NSRC-1:0] sw_set,
    input  logic            en_we,
    input  logic [NSRC-1:0] en_din,
    input  logic            ack,
    output logic [NSRC-1:0] onehot,
    output logic            valid,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] enable,
    output logic            state_dbg
);

    // Handshake: onehot is offered while valid=1 and held unchanged until the
    // edge where ack=1; ack with valid=0 has no effect.

    logic [NSRC-1:0] irq_rise;
    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] pending_q;
    logic [NSRC-1:0] enable_q;
    logic [NSRC-1:0] onehot_q;
    logic            valid_q;
    irq_state_e      state_q;

    for (genvar i = 0; i < NSRC; i++) begin : g_sync
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (irq_in[i]),
            .rise (irq_rise[i])
        );
    end

    assign cand = pending_q & enable_q;
    assign clr  = (state_q == GRANT && ack) ? onehot_q : '0;

    // New sets are ORed in after the clear so a same-edge set survives the ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr) | sw_set | irq_rise;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= '0;
        end else if (en_we) begin
            enable_q <= en_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            onehot_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cand != '0) begin
                        onehot_q <= lowest_set(cand);
                        valid_q  <= 1'b1;
                        state_q  <= GRANT;
                    end
                end
                GRANT: begin
                    // The grant is frozen: later enable changes or higher-priority
                    // arrivals wait for the mandatory idle cycle after ack.
                    if (ack) begin
                        onehot_q <= '0;
                        valid_q  <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    onehot_q <= '0;
                    valid_q  <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign onehot    = onehot_q;
    assign valid     = valid_q;
    assign pending   = pending_q;
    assign enable    = enable_q;
    assign state_dbg = (state_q == GRANT);

endmodule

// File: tb/tb_irq_pending_select.sv
// Directed bench for irq_pending_select with a short randomized invariant run.
module tb_irq_pending_select;
    import irq_pkg::*;

    localparam int SYNC_STAGES = 2;

    logic            clk;
    logic            rst_n;
    logic [NSRC-1:0] irq_in;
    logic [NSRC-1:0] sw_set;
    logic            en_we;
    logic [NSRC-1:0] en_din;
    logic            ack;
    logic [NSRC-1:0] onehot;
    logic            valid;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] enable;
    logic            state_dbg;

    int n_cmp;
    int n_err;
    logic [NSRC-1:0] exp_q[$];

    irq_pending_select #(
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_in   (irq_in),
        .sw_set   (sw_set),
        .en_we    (en_we),
        .en_din   (en_din),
        .ack      (ack),
        .onehot   (onehot),
        .valid    (valid),
        .pending  (pending),
        .enable   (enable),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [NSRC-1:0] got, input logic [NSRC-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic write_enable(input logic [NSRC-1:0] val);
        en_we  = 1'b1;
        en_din = val;
        tick();
        en_we  = 1'b0;
        en_din = '0;
    endtask

    task automatic pulse_sw(input logic [NSRC-1:0] val);
        sw_set = val;
        tick();
        sw_set = '0;
    endtask

    // Expects a live grant of exp, acknowledges it and checks the outputs drop.
    task automatic take_grant(input string tag, input logic [NSRC-1:0] exp);
        check({tag, "_valid"}, {31'b0, valid}, 32'h1);
        check({tag, "_onehot"}, onehot, exp);
        check({tag, "_dbg"}, {31'b0, state_dbg}, 32'h1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({tag, "_valid_after_ack"}, {31'b0, valid}, 32'h0);
        check({tag, "_onehot_after_ack"}, onehot, 32'h0);
    endtask

    initial begin
        int waited;
        int extra_grants;
        logic [NSRC-1:0] want;

        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        irq_in = '0;
        sw_set = '0;
        en_we  = 1'b0;
        en_din = '0;
        ack    = 1'b0;
        #23;
        rst_n = 1'b1;
        #1;
        check("reset_onehot", onehot, 32'h0);
        check("reset_valid", {31'b0, valid}, 32'h0);
        check("reset_pending", pending, 32'h0);
        check("reset_enable", enable, 32'h0);
        tick();

        // 1: single software request, one-edge latency to grant
        write_enable(32'hFFFF_FFFF);
        check("t1_enable", enable, 32'hFFFF_FFFF);
        pulse_sw(32'h0000_0100);
        check("t1_pending", pending, 32'h0000_0100);
        check("t1_not_yet_valid", {31'b0, valid}, 32'h0);
        tick();
        take_grant("t1", 32'h0000_0100);
        check("t1_pending_cleared", pending, 32'h0);

        // 2: three simultaneous requests granted in index order, idle cycle between
        exp_q.push_back(32'h0000_0001);
        exp_q.push_back(32'h0000_0010);
        exp_q.push_back(32'h8000_0000);
        pulse_sw(32'h8000_0011);
        check("t2_pending", pending, 32'h8000_0011);
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            tick();
            take_grant("t2", want);
        end
        check("t2_pending_cleared", pending, 32'h0);

        // 3: IRQ line rises and stays high: one grant, sync latency
        irq_in[5] = 1'b1;
        waited = 0;
        while (!valid && waited < 12) begin
            tick();
            waited++;
            if (waited == SYNC_STAGES + 1)
                check("t3_pending_at_sync", pending, 32'h0000_0020);
        end
        check("t3_latency", waited, SYNC_STAGES + 2);
        take_grant("t3", 32'h0000_0020);
        extra_grants = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid) extra_grants++;
        end
        check("t3_no_regrant", extra_grants, 0);
        check("t3_pending_quiet", pending, 32'h0);
        irq_in[5] = 1'b0;
        repeat (4) tick();

        // 4: grant held across disable and higher-priority arrival
        pulse_sw(32'h0000_0004);
        tick();
        check("t4_onehot", onehot, 32'h0000_0004);
        sw_set = 32'h0000_0001;
        en_we  = 1'b1;
        en_din = 32'h0;
        tick();
        sw_set = '0;
        en_we  = 1'b0;
        check("t4_enable_off", enable, 32'h0);
        check("t4_pending_both", pending, 32'h0000_0005);
        repeat (3) tick();
        take_grant("t4_held", 32'h0000_0004);
        tick();
        check("t4_idle_disabled", {31'b0, valid}, 32'h0);
        check("t4_pending_left", pending, 32'h0000_0001);
        write_enable(32'hFFFF_FFFF);
        tick();
        take_grant("t4_regrant", 32'h0000_0001);

        // 5: ack and re-set of the same bit on one edge: set wins
        pulse_sw(32'h0000_0040);
        tick();
        check("t5_onehot", onehot, 32'h0000_0040);
        ack    = 1'b1;
        sw_set = 32'h0000_0040;
        tick();
        ack    = 1'b0;
        sw_set = '0;
        check("t5_valid_dropped", {31'b0, valid}, 32'h0);
        check("t5_pending_kept", pending, 32'h0000_0040);
        tick();
        take_grant("t5_regrant", 32'h0000_0040);

        // ack while idle is ignored
        pulse_sw(32'h0000_0800);
        ack = 1'b1;
        #2;
        ack = 1'b0;
        check("t5_idle_ack_pending", pending, 32'h0000_0800);
        tick();
        take_grant("t5_after_idle_ack", 32'h0000_0800);

        // 6: asynchronous reset in the middle of a grant
        pulse_sw(32'h0000_0202);
        tick();
        check("t6_onehot", onehot, 32'h0000_0002);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", {31'b0, valid}, 32'h0);
        check("t6_onehot_rst", onehot, 32'h0);
        check("t6_pending_rst", pending, 32'h0);
        check("t6_enable_rst", enable, 32'h0);
        #3;
        rst_n = 1'b1;
        tick();
        write_enable(32'hFFFF_FFFF);
        tick();
        check("t6_lost_grant", {31'b0, valid}, 32'h0);

        // random run: one-hot invariant and valid/onehot consistency
        for (int i = 0; i < 300; i++) begin
            sw_set = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : '0;
            irq_in = ($urandom_range(0, 7) == 0) ? (irq_in ^ (32'h1 << $urandom_range(0, 31))) : irq_in;
            ack    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) begin
                en_we  = 1'b1;
                en_din = $urandom;
            end else begin
                en_we = 1'b0;
            end
            tick();
            check("rnd_onehot0", {31'b0, $onehot0(onehot)}, 32'h1);
            check("rnd_valid_eq", {31'b0, valid}, {31'b0, onehot != '0});
        end
        sw_set = '0;
        irq_in = '0;
        ack    = 1'b0;
        en_we  = 1'b0;

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
